// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor and the ID-stage control unit:
// counter states, branch func3 codes and the PC-to-table-index helper.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  localparam logic [2:0] FUNC3_BEQ = 3'b000;
  localparam logic [2:0] FUNC3_BNE = 3'b001;

  // Instructions are word aligned, so the two LSBs carry no information.
  function automatic int unsigned pc_index(input logic [63:0] pc,
                                           input int unsigned index_bits);
    return 32'((pc >> 2) & ((64'd1 << index_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter with enable and a synchronous reset value.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rst_value,
  input  logic       en,
  input  logic       up,
  output logic [1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_value;
    end else if (en) begin
      if (up) begin
        if (q != ST) q <= q + 2'd1;
      end else begin
        if (q != SNT) q <= q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor: a table of 2-bit saturating counters
// indexed by PC, an IF/ID prediction register and misprediction statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         PC_WIDTH   = 64,
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   if_pc,
  input  logic                  if_id_enable,
  input  logic                  if_id_flush,
  output logic                  if_pred_taken,
  output logic                  id_pred_taken,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_pred_taken,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [1:0]            ctr_q [ENTRIES];

  assign if_idx  = INDEX_BITS'(pc_index(64'(if_pc), INDEX_BITS));
  assign upd_idx = INDEX_BITS'(pc_index(64'(upd_pc), INDEX_BITS));

  // NOTE: the counter table is reset explicitly because every entry must start
  // weakly not-taken; it is flops, not a RAM macro, so this costs nothing extra.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    sat_counter2 u_ctr (
      .clk       (clk),
      .rst       (rst),
      .rst_value (INIT_STATE),
      .en        (upd_valid && (upd_idx == INDEX_BITS'(i))),
      .up        (upd_taken),
      .q         (ctr_q[i])
    );
  end

  // Read-before-write: a same-cycle update becomes visible one cycle later.
  assign if_pred_taken = ctr_q[if_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pred_taken <= 1'b0;
    end else if (if_id_flush) begin
      id_pred_taken <= 1'b0;
    end else if (if_id_enable) begin
      id_pred_taken <= if_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      if (branch_count != '1) branch_count <= branch_count + STAT_WIDTH'(1);
      if ((upd_taken != upd_pred_taken) && (mispredict_count != '1))
        mispredict_count <= mispredict_count + STAT_WIDTH'(1);
    end
  end

endmodule
